// File: rtl/seg_disp_sched_if.sv
// Display scheduler bus: two requester handshakes plus the display-side outputs.
// Handshake rule (both requesters): a value is transferred on a rising sys_clk
// edge where req_x_valid & req_x_ready are both 1; the requester may drop valid
// or change data at any time before that edge, and only the data present at the
// transfer edge is used. disp_valid is a one-cycle strobe with no back-pressure.
interface seg_disp_sched_if;
  logic        req_a_valid;
  logic [15:0] req_a_data;
  logic [3:0]  req_a_tag;
  logic        req_a_ready;
  logic        req_b_valid;
  logic [15:0] req_b_data;
  logic [3:0]  req_b_tag;
  logic        req_b_ready;
  logic [15:0] bcd_digits;
  logic [3:0]  tag_digit;
  logic        disp_src;
  logic        disp_valid;
  logic        ovf;

  // Requesters / display consumer side
  modport master (
    output req_a_valid, req_a_data, req_a_tag,
    input  req_a_ready,
    output req_b_valid, req_b_data, req_b_tag,
    input  req_b_ready,
    input  bcd_digits, tag_digit, disp_src, disp_valid, ovf
  );

  // Scheduler side
  modport slave (
    input  req_a_valid, req_a_data, req_a_tag,
    output req_a_ready,
    input  req_b_valid, req_b_data, req_b_tag,
    output req_b_ready,
    output bcd_digits, tag_digit, disp_src, disp_valid, ovf
  );
endinterface

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin display scheduler for the 5-digit 7-seg driver.
// Accepts a 16-bit value from source A or B, converts it to BCD with a
// sequential shift-add-3 (16 shifts), saturates values above 9999, then holds
// the display for HOLD_CYC cycles before accepting the next value.
// Optional feature macro: SEG_PREEMPT_EN -- while a B value is being held, an
// A request is accepted at once and restarts conversion.
module seg_disp_sched #(
  parameter int unsigned HOLD_CYC = 25_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  seg_disp_sched_if.slave   sched_bus,
  output logic [1:0]        o_dbg_state
);

  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic            r_last_b;     // 1: last grant went to B, so A wins a tie
  logic [15:0]     r_shift;      // binary input, shifted out MSB first
  logic [19:0]     r_bcd;        // 5-digit BCD accumulator
  logic [4:0]      r_bit_cnt;    // shifts done so far (0..16)
  logic [3:0]      r_tag_pend;
  logic            r_src_pend;
  logic [HCW-1:0]  r_hold_cnt;

  logic [15:0]     r_bcd_out;
  logic [3:0]      r_tag_out;
  logic            r_src_out;
  logic            r_disp_valid;
  logic            r_ovf;

  logic            w_a_ready;
  logic            w_b_ready;
  logic            w_take_a;
  logic            w_take_b;
  logic            w_accept;
  logic [19:0]     w_bcd_adj;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [19:0] add3(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_bcd_adj = add3(r_bcd);

  // Ready generation: round-robin in IDLE, optional A preemption of a held B value.
  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sched_bus.req_a_valid && sched_bus.req_b_valid) begin
          if (r_last_b) w_a_ready = 1'b1;
          else          w_b_ready = 1'b1;
        end else if (sched_bus.req_a_valid) begin
          w_a_ready = 1'b1;
        end else if (sched_bus.req_b_valid) begin
          w_b_ready = 1'b1;
        end
      end
      ST_HOLD: begin
`ifdef SEG_PREEMPT_EN
        if (r_src_out) w_a_ready = sched_bus.req_a_valid;
`endif
      end
      default: begin
      end
    endcase
  end

  assign w_take_a = sched_bus.req_a_valid & w_a_ready;
  assign w_take_b = sched_bus.req_b_valid & w_b_ready;
  assign w_accept = w_take_a | w_take_b;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_CONV;
      ST_CONV: if (r_bit_cnt == 5'd16) w_next_state = ST_HOLD;
      ST_HOLD: begin
        if (w_accept)              w_next_state = ST_CONV;
        else if (r_hold_cnt == '0) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Datapath: capture on handshake, shift-add-3 conversion, output update, hold timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_last_b     <= 1'b1;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_bit_cnt    <= '0;
      r_tag_pend   <= '0;
      r_src_pend   <= 1'b0;
      r_hold_cnt   <= '0;
      r_bcd_out    <= '0;
      r_tag_out    <= '0;
      r_src_out    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_disp_valid <= 1'b0;
      if (w_accept) begin
        r_shift    <= w_take_a ? sched_bus.req_a_data : sched_bus.req_b_data;
        r_tag_pend <= w_take_a ? sched_bus.req_a_tag  : sched_bus.req_b_tag;
        r_src_pend <= w_take_b;
        r_last_b   <= w_take_b;
        r_bcd      <= '0;
        r_bit_cnt  <= '0;
      end else begin
        case (r_state)
          ST_CONV: begin
            if (r_bit_cnt != 5'd16) begin
              r_bcd     <= {w_bcd_adj[18:0], r_shift[15]};
              r_shift   <= {r_shift[14:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end else begin
              if (r_bcd[19:16] != 4'd0) begin
                r_bcd_out <= 16'h9999;
                r_ovf     <= 1'b1;
              end else begin
                r_bcd_out <= r_bcd[15:0];
                r_ovf     <= 1'b0;
              end
              r_tag_out    <= r_tag_pend;
              r_src_out    <= r_src_pend;
              r_disp_valid <= 1'b1;
              r_hold_cnt   <= HCW'(HOLD_CYC - 1);
            end
          end
          ST_HOLD: begin
            if (r_hold_cnt != '0) r_hold_cnt <= r_hold_cnt - 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign sched_bus.req_a_ready = w_a_ready;
  assign sched_bus.req_b_ready = w_b_ready;
  assign sched_bus.bcd_digits  = r_bcd_out;
  assign sched_bus.tag_digit   = r_tag_out;
  assign sched_bus.disp_src    = r_src_out;
  assign sched_bus.disp_valid  = r_disp_valid;
  assign sched_bus.ovf         = r_ovf;
  assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Testbench for seg_disp_sched (HOLD_CYC = 10). Directed sequence with a
// scoreboard: each accepted request pushes its expected display word and the
// cycle at which disp_valid must appear; the negedge monitor pops and compares.
module tb_seg_disp_sched;

  localparam int W = 22;  // {ovf, src, tag[3:0], bcd[15:0]}

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] dbg_state;
  int         cyc;
  int         checks;
  int         errors;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];

  seg_disp_sched_if bus();

  seg_disp_sched #(.HOLD_CYC(10)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .sched_bus   (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: decimal digits by division, saturating above 9999.
  function automatic logic [W-1:0] model(input bit src, input logic [15:0] d, input logic [3:0] t);
    logic [15:0] b;
    bit          o;
    if (d > 16'd9999) begin
      b = 16'h9999;
      o = 1'b1;
    end else begin
      b = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
      o = 1'b0;
    end
    return {o, src, t, b};
  endfunction

  // Scoreboard monitor: every disp_valid pulse must match the head of the queue.
  always @(negedge sys_clk) begin
    if (sys_rst_n && bus.disp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(bus.disp_valid), 32'd0);
      end else begin
        logic [W-1:0] e;
        int           et;
        e  = exp_q.pop_front();
        et = exp_t_q.pop_front();
        chk("disp_word", 32'({bus.ovf, bus.disp_src, bus.tag_digit, bus.bcd_digits}), 32'(e));
        chk("disp_cycle", 32'(cyc), 32'(et));
      end
    end
  end

  // Present a request and wait (bounded) for ready; pushes the expectation at the transfer edge.
  task automatic send(input bit src, input logic [15:0] d, input logic [3:0] t,
                      input int budget, output int waited);
    logic rdy;
    if (src) begin
      bus.req_b_valid = 1'b1; bus.req_b_data = d; bus.req_b_tag = t;
    end else begin
      bus.req_a_valid = 1'b1; bus.req_a_data = d; bus.req_a_tag = t;
    end
    waited = 0;
    #1;
    rdy = src ? bus.req_b_ready : bus.req_a_ready;
    while (!rdy && waited < budget) begin
      @(negedge sys_clk); #1;
      waited++;
      rdy = src ? bus.req_b_ready : bus.req_a_ready;
    end
    if (!rdy) begin
      chk("handshake_timeout", 32'(rdy), 32'd1);
    end else begin
      exp_q.push_back(model(src, d, t));
      exp_t_q.push_back(cyc + 1 + 17);
      @(posedge sys_clk); #1;
    end
    if (src) bus.req_b_valid = 1'b0;
    else     bus.req_a_valid = 1'b0;
    @(negedge sys_clk); #2;
  endtask

  // Wait until every pushed expectation has been consumed; leaves us in the pulse cycle.
  task automatic wait_pulse(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge sys_clk); #2;
      n++;
    end
    chk("pulse_wait", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    exp_t_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (dbg_state != 2'd0 && n < budget) begin
      @(negedge sys_clk); #2;
      n++;
    end
    chk("idle_wait", 32'(dbg_state), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bcd"},   32'(bus.bcd_digits), 32'h0);
    chk({tag, "_tag"},   32'(bus.tag_digit), 32'h0);
    chk({tag, "_src"},   32'(bus.disp_src), 32'h0);
    chk({tag, "_valid"}, 32'(bus.disp_valid), 32'h0);
    chk({tag, "_ovf"},   32'(bus.ovf), 32'h0);
    chk({tag, "_state"}, 32'(dbg_state), 32'h0);
  endtask

  initial begin
    int w;
    int t0;
    cyc = 0; checks = 0; errors = 0;
    bus.req_a_valid = 1'b0; bus.req_a_data = '0; bus.req_a_tag = '0;
    bus.req_b_valid = 1'b0; bus.req_b_data = '0; bus.req_b_tag = '0;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk); #2;

    // Reset state, no requests -> no readys
    chk_reset_outputs("rst");
    chk("rst_a_ready", 32'(bus.req_a_ready), 32'd0);
    chk("rst_b_ready", 32'(bus.req_b_ready), 32'd0);

    // A 1234 tag 3: ready in the same cycle, display 17 clocks after the transfer
    send(1'b0, 16'd1234, 4'd3, 0, w);
    chk("a_ready_immediate", 32'(w), 32'd0);
    wait_pulse(40);

    // During HOLD (pulse cycle + 9 more) readys stay 0 even with A asking
    bus.req_a_valid = 1'b1; bus.req_a_data = 16'd65535; bus.req_a_tag = 4'd1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_a_ready", 32'(bus.req_a_ready), 32'd0);
      chk("hold_b_ready", 32'(bus.req_b_ready), 32'd0);
      @(negedge sys_clk); #2;
    end
    #1;
    chk("idle_a_ready", 32'(bus.req_a_ready), 32'd1);
    #1;

    // Saturation and boundary values; tag above 9 passes through
    send(1'b0, 16'd65535, 4'd1, 2, w);
    wait_pulse(40);
    send(1'b0, 16'd9999, 4'd5, 20, w);
    wait_pulse(40);
    send(1'b0, 16'd0, 4'hC, 20, w);
    wait_pulse(40);
    send(1'b0, 16'd10000, 4'd2, 20, w);
    wait_pulse(40);

    // B raised mid-HOLD of A: not ready until IDLE, then accepted in the first IDLE cycle
    send(1'b0, 16'd500, 4'd1, 20, w);
    wait_pulse(40);
    @(negedge sys_clk); #2;
    @(negedge sys_clk); #2;
    bus.req_b_valid = 1'b1; bus.req_b_data = 16'd42; bus.req_b_tag = 4'd7;
    w = 0;
    while (dbg_state == 2'd2 && w < 12) begin
      #1;
      chk("midhold_b_ready", 32'(bus.req_b_ready), 32'd0);
      @(negedge sys_clk); #2;
      w++;
    end
    chk("midhold_len", 32'(w), 32'd8);
    send(1'b1, 16'd42, 4'd7, 0, w);
    chk("b_first_idle", 32'(w), 32'd0);
    wait_pulse(40);

    // Both valid continuously: last grant was B, so A,B,A,B; pulses every 28 cycles
    wait_idle(20);
    bus.req_a_valid = 1'b1; bus.req_a_data = 16'd4095;  bus.req_a_tag = 4'd1;
    bus.req_b_valid = 1'b1; bus.req_b_data = 16'd10000; bus.req_b_tag = 4'd2;
    #1;
    chk("tie_a_ready", 32'(bus.req_a_ready), 32'd1);
    chk("tie_b_ready", 32'(bus.req_b_ready), 32'd0);
    t0 = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? model(1'b0, 16'd4095, 4'd1) : model(1'b1, 16'd10000, 4'd2));
      exp_t_q.push_back(t0 + 17 + 28 * i);
    end
    wait_pulse(150);
    bus.req_a_valid = 1'b0;
    bus.req_b_valid = 1'b0;

    // Reset at CONV step 8 aborts the conversion without a pulse
    wait_idle(20);
    bus.req_a_valid = 1'b1; bus.req_a_data = 16'd7777; bus.req_a_tag = 4'd2;
    #1;
    t0 = cyc + 1;
    @(posedge sys_clk); #1;
    bus.req_a_valid = 1'b0;
    while (cyc < t0 + 8) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk); #2;
    chk_reset_outputs("post_abort");
    send(1'b0, 16'd4321, 4'd6, 0, w);
    wait_pulse(40);

    // B value held, A arrives at HOLD cycle 3
    wait_idle(20);
    send(1'b1, 16'd42, 4'd8, 0, w);
    wait_pulse(40);
    @(negedge sys_clk); #2;
    @(negedge sys_clk); #2;
    send(1'b0, 16'd777, 4'd1, 20, w);
`ifdef SEG_PREEMPT_EN
    chk("preempt_wait", 32'(w), 32'd0);
`else
    chk("no_preempt_wait", 32'(w), 32'd8);
`endif
    wait_pulse(40);

    wait_idle(20);
    repeat (30) @(negedge sys_clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
